// File: rtl/hazard_scoreboard.sv
//==============================================================================
// hazard_scoreboard : ID-stage load-use/RAW/WAW/structural hazard detection
//                     with a pending-writeback scoreboard for the MUL/DIV unit
// Revision 1.0
//==============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  RS1addr_ID_i,
  input  logic [4:0]  RS2addr_ID_i,
  input  logic        RS1use_ID_i,
  input  logic        RS2use_ID_i,
  input  logic [4:0]  RDaddr_ID_i,
  input  logic        RegWrite_ID_i,
  input  logic        LongOp_ID_i,
  input  logic        Flush_i,
  input  logic        MemRead_EX_i,
  input  logic [4:0]  RDaddr_EX_i,
  input  logic        LongDone_i,
  input  logic [4:0]  LongRDaddr_i,
  output logic        Stall_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic [31:0] Pending_o,
  output logic        Busy_o,
  output logic        Error_o,
  output logic [15:0] StallCnt_o
);

  localparam logic [2:0] c_max_out = 3'(MAX_OUT);

  logic [31:1] r_pend;
  logic [2:0]  r_cnt;
  logic        r_err;
  logic [15:0] r_stall_cnt;

  logic [31:0] w_pend;
  logic [31:1] w_pend_next;
  logic        w_lu;
  logic        w_raw;
  logic        w_waw;
  logic        w_str;
  logic        w_stall;
  logic        w_issue;
  logic        w_retire;
  logic        w_set;
  logic        w_bad_done;

  // x0 never waits on a writeback, so bit 0 reads as constant zero
  assign w_pend = {r_pend, 1'b0};

  assign w_lu  = MemRead_EX_i && (RDaddr_EX_i != 5'd0) &&
                 ((RS1use_ID_i && (RDaddr_EX_i == RS1addr_ID_i)) ||
                  (RS2use_ID_i && (RDaddr_EX_i == RS2addr_ID_i)));
  assign w_raw = (RS1use_ID_i && w_pend[RS1addr_ID_i]) ||
                 (RS2use_ID_i && w_pend[RS2addr_ID_i]);
  assign w_waw = RegWrite_ID_i && w_pend[RDaddr_ID_i];
  assign w_str = LongOp_ID_i && (r_cnt == c_max_out);

  // Pending bits are read before any same-cycle retire: no LongDone bypass
  assign w_stall = !Flush_i && (w_lu || w_raw || w_waw || w_str);

  assign w_issue    = LongOp_ID_i && !Flush_i && !w_stall;
  assign w_retire   = LongDone_i && (r_cnt != 3'd0);
  assign w_set      = w_issue && RegWrite_ID_i && (RDaddr_ID_i != 5'd0);
  assign w_bad_done = LongDone_i && ((r_cnt == 3'd0) || !w_pend[LongRDaddr_i]);

  // Set is applied after clear so a same-index collision leaves the bit set
  for (genvar i = 1; i < 32; i++) begin : g_pend
    assign w_pend_next[i] = (r_pend[i] && !(w_retire && (LongRDaddr_i == 5'(i)))) ||
                            (w_set && (RDaddr_ID_i == 5'(i)));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend      <= '0;
      r_cnt       <= 3'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_pend <= w_pend_next;
      if (w_issue && !w_retire) begin
        r_cnt <= r_cnt + 3'd1;
      end else if (w_retire && !w_issue) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_bad_done) begin
        r_err <= 1'b1;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign Stall_o     = w_stall;
  assign PCWrite_o   = !w_stall;
  assign IFIDWrite_o = !w_stall;
  assign NoOp_o      = w_stall;
  assign Pending_o   = w_pend;
  assign Busy_o      = (r_cnt == c_max_out);
  assign Error_o     = r_err;
  assign StallCnt_o  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
//==============================================================================
// tb_hazard_scoreboard : directed + random bench against a rule-level model
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int c_max = 2;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd, rd_ex, lrd;
  logic        rs1_use, rs2_use, reg_write, long_op, flush, mem_read, long_done;
  logic        stall, pc_write, ifid_write, noop, busy, error;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state: which registers await a long writeback, how many ops fly
  bit m_pend [32];
  int m_cnt;
  bit m_err;
  int m_sc;

  hazard_scoreboard #(.MAX_OUT(c_max)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2),
    .RS1use_ID_i(rs1_use), .RS2use_ID_i(rs2_use),
    .RDaddr_ID_i(rd), .RegWrite_ID_i(reg_write), .LongOp_ID_i(long_op),
    .Flush_i(flush), .MemRead_EX_i(mem_read), .RDaddr_EX_i(rd_ex),
    .LongDone_i(long_done), .LongRDaddr_i(lrd),
    .Stall_o(stall), .PCWrite_o(pc_write), .IFIDWrite_o(ifid_write),
    .NoOp_o(noop), .Pending_o(pending), .Busy_o(busy), .Error_o(error),
    .StallCnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    m_sc  = 0;
  endtask

  function automatic bit m_stall();
    bit lu, raw, waw, str;
    lu  = mem_read && rd_ex != 0 && ((rs1_use && rd_ex == rs1) || (rs2_use && rd_ex == rs2));
    raw = (rs1_use && m_pend[rs1]) || (rs2_use && m_pend[rs2]);
    waw = reg_write && m_pend[rd];
    str = long_op && m_cnt == c_max;
    return !flush && (lu || raw || waw || str);
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic eval_now();
    bit s;
    @(negedge clk);
    s = m_stall();
    check("stall", 32'(stall), 32'(s));
    check("pcwrite", 32'(pc_write), 32'(!s));
    check("ifidwrite", 32'(ifid_write), 32'(!s));
    check("noop", 32'(noop), 32'(s));
    check("pending", pending, m_pend_vec());
    check("busy", 32'(busy), 32'(m_cnt == c_max));
    check("error", 32'(error), 32'(m_err));
    check("stallcnt", 32'(stall_cnt), 32'(m_sc));
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic advance();
    bit s, issue;
    s = m_stall();
    issue = long_op && !flush && !s;
    if (!rst_n) begin
      m_reset();
    end else begin
      if (long_done) begin
        if (m_cnt == 0) m_err = 1'b1;
        else begin
          if (!m_pend[lrd]) m_err = 1'b1;
          m_pend[lrd] = 1'b0;
          m_cnt--;
        end
      end
      if (issue) begin
        m_cnt++;
        if (reg_write && rd != 0) m_pend[rd] = 1'b1;
      end
      if (s && m_sc < 65535) m_sc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval_now();
    advance();
  endtask

  task automatic set_idle();
    rs1 = 0; rs2 = 0; rd = 0; rd_ex = 0; lrd = 0;
    rs1_use = 0; rs2_use = 0; reg_write = 0; long_op = 0; flush = 0;
    mem_read = 0; long_done = 0;
  endtask

  task automatic issue_mul(input logic [4:0] dst);
    set_idle();
    long_op = 1; reg_write = 1; rd = dst;
  endtask

  task automatic rand_inputs();
    int start, idx;
    bit found;
    rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7)); rd_ex = 5'($urandom_range(0, 7));
    rs1_use   = 1'($urandom_range(0, 1));
    rs2_use   = 1'($urandom_range(0, 1));
    reg_write = 1'($urandom_range(0, 1));
    long_op   = ($urandom_range(0, 2) == 0);
    flush     = ($urandom_range(0, 7) == 0);
    mem_read  = ($urandom_range(0, 3) == 0);
    long_done = ($urandom_range(0, 3) == 0);
    found = 0;
    start = int'($urandom_range(0, 31));
    lrd = 5'($urandom_range(0, 7));
    for (int k = 0; k < 32; k++) begin
      idx = (start + k) % 32;
      if (!found && m_pend[idx]) begin
        lrd = 5'(idx);
        found = 1;
      end
    end
  endtask

  initial begin
    set_idle();
    m_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state; a load-use hazard still stalls while held in reset
    mem_read = 1; rd_ex = 5; rs1 = 5; rs1_use = 1; rs2 = 7; rs2_use = 1; rd = 6; reg_write = 1;
    eval_now();
    check("rst_pending", pending, 32'h0);
    check("rst_stallcnt", 32'(stall_cnt), 32'h0);
    check("rst_lu_stall", 32'(stall), 32'h1);
    advance();
    rst_n = 1;

    // Load-use: exactly one stall once EX advances
    eval_now();
    check("lu_stall", 32'(stall), 32'h1);
    check("lu_pcwrite", 32'(pc_write), 32'h0);
    advance();
    mem_read = 0;
    eval_now();
    check("lu_release", 32'(stall), 32'h0);
    advance();
    mem_read = 1; rd_ex = 0; rs1 = 0;
    eval_now();
    check("lu_x0", 32'(stall), 32'h0);
    advance();

    // RAW against a long op, held through the LongDone cycle
    issue_mul(3); rs1 = 1; rs1_use = 1; rs2 = 2; rs2_use = 1;
    eval_now();
    check("mul3_issue", 32'(stall), 32'h0);
    advance();
    set_idle(); rs2 = 3; rs2_use = 1; rd = 11; reg_write = 1;
    eval_now();
    check("raw_pend3", 32'(pending[3]), 32'h1);
    check("raw_stall1", 32'(stall), 32'h1);
    advance();
    step();
    long_done = 1; lrd = 3;
    eval_now();
    check("raw_stall_done", 32'(stall), 32'h1);
    advance();
    long_done = 0;
    eval_now();
    check("raw_release", 32'(stall), 32'h0);
    check("raw_stallcnt", 32'(stall_cnt), 32'd4);
    advance();

    // Structural limit
    issue_mul(1); step();
    issue_mul(2); step();
    issue_mul(10);
    eval_now();
    check("str_busy", 32'(busy), 32'h1);
    check("str_stall", 32'(stall), 32'h1);
    advance();
    long_done = 1; lrd = 1;
    eval_now();
    check("str_stall_done", 32'(stall), 32'h1);
    advance();
    long_done = 0;
    eval_now();
    check("str_busy_drop", 32'(busy), 32'h0);
    check("str_issue", 32'(stall), 32'h0);
    advance();
    set_idle();
    eval_now();
    check("str_busy_again", 32'(busy), 32'h1);
    check("str_pend10", 32'(pending[10]), 32'h1);
    long_done = 1; lrd = 2;
    advance();
    step();
    long_done = 1; lrd = 10;
    step();

    // WAW and simultaneous issue/retire
    issue_mul(4); step();
    set_idle(); rd = 4; reg_write = 1;
    eval_now();
    check("waw_stall", 32'(stall), 32'h1);
    advance();
    set_idle(); long_done = 1; lrd = 4; step();
    issue_mul(9); step();
    issue_mul(8); long_done = 1; lrd = 9;
    eval_now();
    check("sim_issue", 32'(stall), 32'h0);
    advance();
    set_idle();
    eval_now();
    check("sim_pend8", 32'(pending[8]), 32'h1);
    check("sim_pend9", 32'(pending[9]), 32'h0);
    check("sim_busy", 32'(busy), 32'h0);
    long_done = 1; lrd = 8;
    advance();

    // Flush suppresses stall and issue
    issue_mul(12); flush = 1; mem_read = 1; rd_ex = 13; rs1 = 13; rs1_use = 1;
    eval_now();
    check("flush_stall", 32'(stall), 32'h0);
    advance();
    set_idle();
    eval_now();
    check("flush_pend12", 32'(pending[12]), 32'h0);
    check("flush_busy", 32'(busy), 32'h0);
    advance();

    // Spurious writeback with nothing in flight
    long_done = 1; lrd = 5;
    step();
    set_idle();
    eval_now();
    check("err_set", 32'(error), 32'h1);
    advance();
    repeat (3) step();
    eval_now();
    check("err_sticky", 32'(error), 32'h1);
    advance();

    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of a stall
    issue_mul(20); step();
    set_idle(); rs1 = 20; rs1_use = 1; mem_read = 1; rd_ex = 21; rs2 = 21; rs2_use = 1;
    #3;
    rst_n = 0;
    #1;
    check("async_pending", pending, 32'h0);
    check("async_stallcnt", 32'(stall_cnt), 32'h0);
    check("async_error", 32'(error), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    set_idle(); long_done = 1; lrd = 20;
    step();
    set_idle();
    eval_now();
    check("late_done_err", 32'(error), 32'h1);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
